mod_mem_burst: RTL and testbench
================================

MOD_MEM_BURST -- requirements
Module: mod_mem_burst

Interface
REQ-001 Parameter SIZE, default 640*480*3*4: storage capacity in bytes.
REQ-002 Parameter DATA_BYTES, default 4 (legal 1, 2, 4, 8): bytes per beat; DW = 8*DATA_BYTES.
REQ-003 Parameter LEN_W, default 8: width of burst-length field.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid / req_ready  in / out  1 / 1  command handshake.
REQ-007 req_write  input  1  1 = write burst, 0 = read burst.
REQ-008 req_addr  input  32  start byte address.
REQ-009 req_len  input  LEN_W  beats minus one.
REQ-010 wr_valid / wr_ready  in / out  1 / 1  write-data handshake.
REQ-011 wr_data / wr_strb / wr_last  input  DW / DATA_BYTES / 1  write beat, byte lanes, last flag.
REQ-012 rd_valid / rd_ready  out / in  1 / 1  read-data handshake.
REQ-013 rd_data / rd_last / rd_err  output  DW / 1 / 1  read beat, final-beat flag, beat out of range.
REQ-014 resp_valid / resp_ready / resp_err  out / in / out  write-completion handshake and error.

Function
REQ-015 A transfer occurs on a rising edge where valid and ready are both 1; valid, once raised, is held with payload stable until the transfer.
REQ-016 FSM states are IDLE, WRITE, READ, RESP; req_ready = 1 only in IDLE.
REQ-017 IDLE to WRITE or READ on a command transfer per req_write; the address is aligned down to a DATA_BYTES multiple and the beat counter is loaded with req_len.
REQ-018 WRITE: wr_ready = 1; each transfer stores wr_data byte i to store[addr+i] only where wr_strb[i] = 1; addr advances by DATA_BYTES; after beat req_len the FSM goes to RESP.
REQ-019 Beat count is governed only by req_len; wr_last mismatch (1 on a non-final beat, or 0 on the final beat) sets the sticky burst error and does not alter the beat count.
REQ-020 RESP: resp_valid = 1 and resp_err = burst error; on the resp transfer the FSM goes to IDLE and the error clears.
REQ-021 READ: rd_valid rises the cycle after the command transfer with beat 0 registered in rd_data (lane i = store[addr+i]); each rd transfer presents the next beat the following cycle with no bubble.
REQ-022 rd_last = 1 on beat req_len only; after that transfer rd_valid drops and the FSM returns to IDLE.
REQ-023 rd_valid low, or rd_ready low, holds rd_data, rd_last and rd_err unchanged.
REQ-024 A beat whose byte address plus lane reaches SIZE or beyond is out of range: the write to that lane is suppressed and sets the burst error; a read returns 0 in that lane and rd_err = 1 for that beat; no wrap-around occurs.
REQ-025 Address arithmetic is 33-bit so address overflow past 2^32-1 is treated as out of range.
REQ-026 A read command issued after a write's resp transfer returns the written data.
REQ-027 Backdoor functions bd_write(addr, byte) and bd_read(addr) access the same byte storage with zero time, for test preload and dump, and do not affect the FSM.

Reset
REQ-028 reset_n = 0 forces IDLE asynchronously; req_ready = 1; wr_ready, rd_valid, rd_last, rd_err, resp_valid, resp_err = 0; rd_data = 0.
REQ-029 Reset mid-burst aborts it: beats already written are kept, memory contents are never cleared, and the pending response is discarded.
REQ-030 The first command is accepted on the first rising edge after reset_n rises.

Verification
REQ-031 Write addr 0x10, len 3, data 0x11111111..0x44444444, strb 0xF, last on beat 3 -> resp_err 0; bd_read(0x10..0x1F) returns bytes 11 x4, 22 x4, 33 x4, 44 x4.
REQ-032 Read addr 0x12, len 1 after REQ-031 -> aligned to 0x10; rd_data 0x11111111 then 0x22222222; rd_last on beat 1 only; rd_err 0.
REQ-033 Write strb 0x5 with data 0xAABBCCDD at 0x20 over preloaded 0x00 bytes -> bd_read(0x20..0x23) returns DD, 00, BB, 00.
REQ-034 Read at SIZE-4, len 1, rd_ready toggled 1/0 every cycle -> beat 0 has valid data and rd_err 0; beat 1 has data 0 and rd_err 1; data held stable while rd_ready is 0.
REQ-035 Write len 2 with wr_last on beat 1 -> three beats are written and resp_err = 1.
REQ-036 reset_n pulsed low after beat 1 of a 4-beat write -> outputs reach reset values immediately; beats 0-1 remain in memory; the next command is accepted.

Source files
------------

// File: rtl/mod_mem_burst.sv
// Burst byte memory: command, write-data, read-data and write-response
// valid/ready channels; lanes at or beyond SIZE are dropped and flagged.
module mod_mem_burst #(
    parameter int SIZE       = 640*480*3*4,
    parameter int DATA_BYTES = 4,
    parameter int LEN_W      = 8,
    localparam int DW        = 8*DATA_BYTES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [31:0]           req_addr,
    input  logic [LEN_W-1:0]      req_len,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DW-1:0]         wr_data,
    input  logic [DATA_BYTES-1:0] wr_strb,
    input  logic                  wr_last,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DW-1:0]         rd_data,
    output logic                  rd_last,
    output logic                  rd_err,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_err
);

    localparam int          AW    = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [32:0] LIMIT = 33'(SIZE);
    localparam logic [32:0] STEP  = 33'(DATA_BYTES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [7:0]       mem_q [SIZE];
    logic [1:0]       state_q, state_d;
    logic [32:0]      addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_last_q, rd_last_d;
    logic             rd_err_q, rd_err_d;
    logic [DW-1:0]    rd_data_q, rd_data_d;

    logic [32:0]           req_base;
    logic [32:0]           fetch_addr;
    logic [DW-1:0]         fetch_data;
    logic                  fetch_err;
    logic [DATA_BYTES-1:0] wr_en;
    logic [AW-1:0]         wr_idx [DATA_BYTES];
    logic                  wr_oob;

    assign req_base   = {1'b0, req_addr & ~32'(DATA_BYTES-1)};
    assign fetch_addr = (state_q == S_IDLE) ? req_base : addr_q;

    // 33-bit lane addresses: carry past 2^32 lands above SIZE, never wraps
    always_comb begin
        logic [32:0] la;
        la         = '0;
        fetch_data = '0;
        fetch_err  = 1'b0;
        wr_en      = '0;
        wr_oob     = 1'b0;
        for (int i = 0; i < DATA_BYTES; i++) begin
            wr_idx[i] = '0;
            la = fetch_addr + 33'(i);
            if (la < LIMIT) begin
                fetch_data[8*i +: 8] = mem_q[la[AW-1:0]];
            end else begin
                fetch_err = 1'b1;
            end
            la = addr_q + 33'(i);
            if (la < LIMIT) begin
                wr_idx[i] = la[AW-1:0];
                wr_en[i]  = (state_q == S_WRITE) && wr_valid && wr_strb[i];
            end else begin
                wr_oob = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        rd_err_d   = rd_err_q;
        rd_data_d  = rd_data_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cnt_d = req_len;
                    err_d = 1'b0;
                    if (req_write) begin
                        state_d = S_WRITE;
                        addr_d  = req_base;
                    end else begin
                        state_d    = S_READ;
                        addr_d     = req_base + STEP;
                        rd_valid_d = 1'b1;
                        rd_data_d  = fetch_data;
                        rd_err_d   = fetch_err;
                        rd_last_d  = (req_len == '0);
                    end
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    addr_d = addr_q + STEP;
                    cnt_d  = cnt_q - 1'b1;
                    if (wr_oob || (wr_last != (cnt_q == '0))) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == '0) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_READ: begin
                if (rd_ready) begin
                    if (rd_last_q) begin
                        state_d    = S_IDLE;
                        rd_valid_d = 1'b0;
                    end else begin
                        addr_d    = addr_q + STEP;
                        cnt_d     = cnt_q - 1'b1;
                        rd_data_d = fetch_data;
                        rd_err_d  = fetch_err;
                        rd_last_d = (cnt_q == LEN_W'(1));
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            rd_err_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            rd_err_q   <= rd_err_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Storage survives reset; writes stop because reset forces IDLE
    always_ff @(posedge clk) begin
        for (int i = 0; i < DATA_BYTES; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_idx[i]] <= wr_data[8*i +: 8];
            end
        end
    end

    function automatic void bd_write(input logic [31:0] addr, input logic [7:0] b);
        if ({1'b0, addr} < LIMIT) begin
            mem_q[addr[AW-1:0]] = b;
        end
    endfunction

    function automatic logic [7:0] bd_read(input logic [31:0] addr);
        logic [7:0] r;
        r = '0;
        if ({1'b0, addr} < LIMIT) begin
            r = mem_q[addr[AW-1:0]];
        end
        return r;
    endfunction

    assign req_ready  = (state_q == S_IDLE);
    assign wr_ready   = (state_q == S_WRITE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_err   = (state_q == S_RESP) && err_q;
    assign rd_valid   = rd_valid_q;
    assign rd_last    = rd_last_q;
    assign rd_err     = rd_err_q;
    assign rd_data    = rd_data_q;

endmodule

// File: tb/tb_mod_mem_burst.sv
// Randomized bench for mod_mem_burst against a flat byte-array model.
// Directed cases cover alignment, strobes, range edge, last mismatch, reset.
module tb_mod_mem_burst;

    localparam int SIZE = 4096;
    localparam int DB   = 4;
    localparam int LW   = 8;
    localparam int DW   = 8*DB;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [LW-1:0] req_len = '0;
    logic          wr_valid = 1'b0, wr_ready, wr_last = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic [DB-1:0] wr_strb = '0;
    logic          rd_valid, rd_ready = 1'b0, rd_last, rd_err;
    logic [DW-1:0] rd_data;
    logic          resp_valid, resp_ready = 1'b0, resp_err;

    int            vec_cnt = 0;
    int            err_cnt = 0;
    int            cmd_waits = 0;
    logic [7:0]    mdl [SIZE];
    logic [DW-1:0] wdat [256];
    logic [DB-1:0] wstb [256];

    mod_mem_burst #(.SIZE(SIZE), .DATA_BYTES(DB), .LEN_W(LW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_data(wr_data), .wr_strb(wr_strb), .wr_last(wr_last),
        .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .rd_last(rd_last), .rd_err(rd_err),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] exp_beat(input longint base, input int b,
                                               output bit oob);
        logic [DW-1:0] r;
        longint ad;
        r = '0;
        oob = 1'b0;
        for (int i = 0; i < DB; i++) begin
            ad = base + longint'(b) * DB + i;
            if (ad >= SIZE) oob = 1'b1;
            else r[8*i +: 8] = mdl[int'(ad)];
        end
        return r;
    endfunction

    task automatic send_cmd(input bit w, input logic [31:0] a, input int len);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_len   = LW'(len);
        cmd_waits = 0;
        @(negedge clk);
        while (!req_ready && cmd_waits < 50) begin
            cmd_waits++;
            @(negedge clk);
        end
        if (!req_ready) check("req_ready_timeout", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wr_burst(input logic [31:0] a, input int len, input int last_pos,
                            input bit gaps, input int abort_at);
        longint base;
        longint ad;
        bit     exp_err;
        int     n;
        base = longint'(a) & ~longint'(DB-1);
        exp_err = 1'b0;
        send_cmd(1'b1, a, len);
        for (int b = 0; b <= len; b++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            wr_valid = 1'b1;
            wr_data  = wdat[b];
            wr_strb  = wstb[b];
            wr_last  = (b == last_pos);
            n = 0;
            @(negedge clk);
            while (!wr_ready && n < 50) begin
                n++;
                @(negedge clk);
            end
            if (!wr_ready) check("wr_ready_timeout", 64'(wr_ready), 64'd1);
            @(posedge clk);
            #1;
            wr_valid = 1'b0;
            wr_last  = 1'b0;
            for (int i = 0; i < DB; i++) begin
                ad = base + longint'(b) * DB + i;
                if (ad >= SIZE) exp_err = 1'b1;
                else if (wstb[b][i]) mdl[int'(ad)] = wdat[b][8*i +: 8];
            end
            if ((b == last_pos) != (b == len)) exp_err = 1'b1;
            if (b == abort_at) return;
        end
        if (gaps) repeat ($urandom_range(0, 2)) tick();
        resp_ready = 1'b1;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 50) begin
            n++;
            @(negedge clk);
        end
        check("resp_valid", 64'(resp_valid), 64'd1);
        check("resp_err", 64'(resp_err), 64'(exp_err));
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
    endtask

    task automatic rd_burst(input logic [31:0] a, input int len, input int mode);
        longint        base;
        logic [DW-1:0] e, hd;
        logic          hl, he, hold, tgl;
        bit            oob;
        int            b, cyc;
        base = longint'(a) & ~longint'(DB-1);
        send_cmd(1'b0, a, len);
        b = 0; cyc = 0; hold = 1'b0; tgl = 1'b0;
        hd = '0; hl = 1'b0; he = 1'b0; e = '0;
        while (b <= len && cyc < 500) begin
            rd_ready = (mode == 0) ? 1'b1 : (mode == 1) ? tgl : 1'($urandom_range(0, 1));
            tgl = ~tgl;
            @(negedge clk);
            check("rd_valid", 64'(rd_valid), 64'd1);
            if (hold) begin
                check("hold_data", 64'(rd_data), 64'(hd));
                check("hold_last", 64'(rd_last), 64'(hl));
                check("hold_err", 64'(rd_err), 64'(he));
            end
            if (rd_ready) begin
                e = exp_beat(base, b, oob);
                check("rd_data", 64'(rd_data), 64'(e));
                check("rd_last", 64'(rd_last), 64'(b == len));
                check("rd_err", 64'(rd_err), 64'(oob));
                b++;
                hold = 1'b0;
            end else begin
                hold = 1'b1;
                hd = rd_data; hl = rd_last; he = rd_err;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (b <= len) check("rd_timeout", 64'(b), 64'(len + 1));
        rd_ready = 1'b0;
        @(negedge clk);
        check("rd_valid_drop", 64'(rd_valid), 64'd0);
        check("rd_idle_hold", 64'(rd_data), 64'(e));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        check({tag, "_wr_ready"}, 64'(wr_ready), 64'd0);
        check({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        check({tag, "_rd_last"}, 64'(rd_last), 64'd0);
        check({tag, "_rd_err"}, 64'(rd_err), 64'd0);
        check({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
        check({tag, "_resp_err"}, 64'(resp_err), 64'd0);
        check({tag, "_rd_data"}, 64'(rd_data), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, lp, r;
        logic [31:0] a;
        #2;
        check_reset_outputs("por");
        @(posedge clk);
        #2;
        reset_n = 1'b1;

        for (int k = 0; k < SIZE / (256 * DB); k++) begin
            for (int b = 0; b < 256; b++) begin
                wdat[b] = DW'($urandom);
                wstb[b] = '1;
            end
            wr_burst(32'(k * 256 * DB), 255, 255, 1'b0, -1);
            if (k == 0) check("first_cmd_wait", 64'(cmd_waits), 64'd0);
        end

        for (int b = 0; b < 4; b++) begin
            wdat[b] = DW'(32'h1111_1111 * (b + 1));
            wstb[b] = '1;
        end
        wr_burst(32'h10, 3, 3, 1'b1, -1);
        for (int i = 0; i < 16; i++)
            check("bd_burst4", 64'(dut.bd_read(32'h10 + 32'(i))), 64'(8'h11 * (i / 4 + 1)));
        rd_burst(32'h12, 1, 0);

        wdat[0] = '0;
        wstb[0] = '1;
        wr_burst(32'h20, 0, 0, 1'b0, -1);
        wdat[0] = 32'hAABB_CCDD;
        wstb[0] = 4'h5;
        wr_burst(32'h20, 0, 0, 1'b0, -1);
        check("strb_b0", 64'(dut.bd_read(32'h20)), 64'h0DD);
        check("strb_b1", 64'(dut.bd_read(32'h21)), 64'h000);
        check("strb_b2", 64'(dut.bd_read(32'h22)), 64'h0BB);
        check("strb_b3", 64'(dut.bd_read(32'h23)), 64'h000);

        rd_burst(32'(SIZE - 4), 1, 1);

        for (int b = 0; b < 4; b++) begin
            wdat[b] = DW'($urandom);
            wstb[b] = '1;
        end
        wr_burst(32'h40, 2, 1, 1'b1, -1);
        check("early_last_b2", 64'(dut.bd_read(32'h48)), 64'(wdat[2][7:0]));

        for (int b = 0; b < 4; b++) begin
            wdat[b] = DW'($urandom);
            wstb[b] = '1;
        end
        wr_burst(32'h80, 3, 3, 1'b0, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #2;
        reset_n = 1'b1;
        rd_burst(32'h80, 3, 0);
        check("rst_cmd_wait", 64'(cmd_waits), 64'd0);

        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r < 7) a = 32'($urandom_range(0, SIZE - 1));
            else if (r == 7) a = 32'(SIZE - 16) + 32'($urandom_range(0, 15));
            else if (r == 8) a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            else a = 32'(SIZE) + 32'($urandom_range(0, 100));
            len = $urandom_range(0, 7);
            if ($urandom_range(0, 1) == 1) begin
                for (int b = 0; b <= len; b++) begin
                    wdat[b] = DW'($urandom);
                    wstb[b] = DB'($urandom);
                end
                lp = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len + 1) : len;
                wr_burst(a, len, lp, 1'b1, -1);
            end else begin
                rd_burst(a, len, $urandom_range(0, 2));
            end
        end

        for (int i = 0; i < SIZE; i++)
            check("mem_sweep", 64'(dut.bd_read(32'(i))), 64'(mdl[i]));

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
